// File: rtl/readback_pkg.sv
// Shared definitions for the COBI chain sequencers: address field layout,
// sequencer state encodings and the chip-index width derivation.
`ifndef READBACK_MAX2
`define READBACK_MAX2
`define MAX2(a, b) (((a) > (b)) ? (a) : (b))
`endif

package readback_pkg;

  localparam int COL_LSB  = 0;
  localparam int ROW_LSB  = 6;
  localparam int CHIP_LSB = 12;
  localparam int FIELD_W  = 6;
  localparam int CELL_W   = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD_EN = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;
  localparam logic [1:0] S_INC   = 2'd3;

  function automatic int chip_addr_w(input int num_chips);
    return `MAX2($clog2(num_chips), 1);
  endfunction

endpackage

// File: rtl/readback_if.sv
// Read-back word stream: one sampled cell word tagged with its {chip,row,col}.
interface readback_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 13
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_last;

  modport master (output out_valid, out_data, out_addr, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_addr, out_last, output out_ready);
endinterface

// File: rtl/readback_addr_counter.sv
// Chain address walker shared by the programming and read-back sequencers:
// {chip,row,col} register, split-field view, last-cell detect, one-hot enable.
module cobi_chain_addr_counter
  import readback_pkg::*;
#(
  parameter int NUM_CHIPS = 1,
  parameter int CAW       = chip_addr_w(NUM_CHIPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  inc_i,
  input  logic                  gate_i,
  output logic [CELL_W+CAW-1:0] addr_o,
  output logic                  last_o,
  output logic [FIELD_W-1:0]    row_o,
  output logic [FIELD_W-1:0]    col_o,
  output logic [CAW-1:0]        chip_o,
  output logic [NUM_CHIPS-1:0]  en_o
);
  localparam int AW = CELL_W + CAW;

  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr_i)      addr_d = '0;
    else if (inc_i) addr_d = addr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr_o = addr_q;
  assign col_o  = addr_q[COL_LSB  +: FIELD_W];
  assign row_o  = addr_q[ROW_LSB  +: FIELD_W];
  assign chip_o = addr_q[CHIP_LSB +: CAW];
  assign last_o = (addr_q[CELL_W-1:0] == '1) && (chip_o == CAW'(NUM_CHIPS - 1));

  // Gate shifted to the addressed chip; a chip index past the chain end enables nothing.
  for (genvar c = 0; c < NUM_CHIPS; c++) begin : g_en
    assign en_o[c] = gate_i && (chip_o == CAW'(c));
  end

endmodule

// File: rtl/readback.sv
// COBI weight-array read-back sequencer: scans every cell of the chain, pulses
// its read enable for a settle window, samples the data and streams it out.
module readback
  import readback_pkg::*;
#(
  parameter  int NUM_CHIPS_PER_CHAIN = 1,
  parameter  int DATA_WIDTH          = 4,
  parameter  int SETTLE_CLOCKS       = 4,
  localparam int CHIP_ADDR_WIDTH     = chip_addr_w(NUM_CHIPS_PER_CHAIN)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           ready,
  output logic [5:0]                     row_addr,
  output logic [5:0]                     col_addr,
  output logic [CHIP_ADDR_WIDTH-1:0]     chip_in_chain_addr,
  output logic [NUM_CHIPS_PER_CHAIN-1:0] rd_en,
  input  logic [DATA_WIDTH-1:0]          rd_data,
  readback_if.master                     out_if
);
  localparam int AW    = CELL_W + CHIP_ADDR_WIDTH;
  localparam int CNT_W = `MAX2($clog2(SETTLE_CLOCKS + 1), 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rd_gate_q, rd_gate_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]         oaddr_q, oaddr_d;

  logic          addr_clr, addr_inc, cell_last;
  logic [AW-1:0] addr;

  cobi_chain_addr_counter #(
    .NUM_CHIPS (NUM_CHIPS_PER_CHAIN),
    .CAW       (CHIP_ADDR_WIDTH)
  ) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (addr_clr),
    .inc_i  (addr_inc),
    .gate_i (rd_gate_q),
    .addr_o (addr),
    .last_o (cell_last),
    .row_o  (row_addr),
    .col_o  (col_addr),
    .chip_o (chip_in_chain_addr),
    .en_o   (rd_en)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_gate_d = rd_gate_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    oaddr_d   = oaddr_q;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    // A new start abandons whatever the scan was doing, including a pending word.
    if (start) begin
      ready_d   = 1'b0;
      addr_clr  = 1'b1;
      cnt_d     = '0;
      rd_gate_d = 1'b0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      state_d   = S_RD_EN;
    end else begin
      case (state_q)
        S_RD_EN: begin
          rd_gate_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SETTLE_CLOCKS)) begin
            data_d    = rd_data;
            oaddr_d   = addr;
            valid_d   = 1'b1;
            last_d    = cell_last;
            rd_gate_d = 1'b0;
            state_d   = S_OUT;
          end
        end
        S_OUT: begin
          if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_INC;
          end
        end
        S_INC: begin
          // Address only moves here, well clear of the falling read enable.
          addr_inc = 1'b1;
          if (cell_last) begin
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_RD_EN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_gate_q <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      oaddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_gate_q <= rd_gate_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      oaddr_q   <= oaddr_d;
    end
  end

  assign ready            = ready_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_addr  = oaddr_q;

endmodule

// File: tb/tb_readback.sv
// Bench for readback: two chains (1 chip / settle 4, 3 chips / settle 1) run in
// parallel against random chip memories and an address-sequence scoreboard.
module tb_readback;
  import readback_pkg::*;

  localparam int DW    = 4;
  localparam int NA    = 1;
  localparam int SA    = 4;
  localparam int NB    = 3;
  localparam int SB    = 1;
  localparam int CAWA  = chip_addr_w(NA);
  localparam int CAWB  = chip_addr_w(NB);
  localparam int AWA   = 12 + CAWA;
  localparam int AWB   = 12 + CAWB;
  localparam int CELLS = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] mem_a [NA*CELLS];
  logic [DW-1:0] mem_b [NB*CELLS];

  // ---------------- chain A ----------------
  logic            rst_n_a, start_a, ready_a;
  logic [5:0]      row_a, col_a;
  logic [CAWA-1:0] chip_a;
  logic [NA-1:0]   rd_en_a;
  logic [DW-1:0]   rd_data_a;
  readback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWA)) if_a ();

  readback #(.NUM_CHIPS_PER_CHAIN(NA), .DATA_WIDTH(DW), .SETTLE_CLOCKS(SA)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .ready(ready_a),
    .row_addr(row_a), .col_addr(col_a), .chip_in_chain_addr(chip_a),
    .rd_en(rd_en_a), .rd_data(rd_data_a), .out_if(if_a)
  );

  // ---------------- chain B ----------------
  logic            rst_n_b, start_b, ready_b;
  logic [5:0]      row_b, col_b;
  logic [CAWB-1:0] chip_b;
  logic [NB-1:0]   rd_en_b;
  logic [DW-1:0]   rd_data_b;
  readback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWB)) if_b ();

  readback #(.NUM_CHIPS_PER_CHAIN(NB), .DATA_WIDTH(DW), .SETTLE_CLOCKS(SB)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .ready(ready_b),
    .row_addr(row_b), .col_addr(col_b), .chip_in_chain_addr(chip_b),
    .rd_en(rd_en_b), .rd_data(rd_data_b), .out_if(if_b)
  );

  // Chip models: enabled chip returns its stored cell, otherwise the bus is garbage.
  always @(negedge clk) begin
    rd_data_a = rd_en_a[0] ? mem_a[{row_a, col_a}] : DW'($urandom);
  end

  always @(negedge clk) begin
    int c;
    c = -1;
    for (int i = 0; i < NB; i++) if (rd_en_b[i]) c = i;
    rd_data_b = (c >= 0) ? mem_b[c*CELLS + int'({row_b, col_b})] : DW'($urandom);
  end

  // ---------------- monitor A ----------------
  int             exp_a = 0, words_a = 0, width_a = 0, since_fall_a = 0, last_rise_a = -1;
  bit             prev_en_a = 0, moved_a = 0, per_chk_a = 0, hold_pend_a = 0;
  logic [AWA-1:0] pulse_addr_a, cur_a;

  always @(negedge clk) begin
    cur_a = {chip_a, row_a, col_a};
    if (!rst_n_a) begin
      prev_en_a   = 0;
      hold_pend_a = 0;
      last_rise_a = -1;
    end else begin
      if (!start_a && if_a.out_valid && if_a.out_ready) begin
        chk("a_addr", if_a.out_addr, exp_a);
        chk("a_data", if_a.out_data, mem_a[exp_a % (NA*CELLS)]);
        chk("a_last", if_a.out_last, exp_a == NA*CELLS-1);
        exp_a++;
        words_a++;
      end
      if (rd_en_a[0]) begin
        if (!prev_en_a) begin
          if (per_chk_a && last_rise_a >= 0) chk("a_period", cyc - last_rise_a, SA + 3);
          last_rise_a  = cyc;
          width_a      = 0;
          moved_a      = 0;
          pulse_addr_a = cur_a;
        end
        width_a++;
        if (cur_a != pulse_addr_a) moved_a = 1;
      end else if (prev_en_a) begin
        chk("a_width", width_a, SA);
        chk("a_addr_stable", moved_a, 0);
        chk("a_tag", if_a.out_addr, pulse_addr_a);
        hold_pend_a  = 1;
        since_fall_a = 0;
      end
      if (!rd_en_a[0] && hold_pend_a) begin
        since_fall_a++;
        if (cur_a != pulse_addr_a) begin
          chk("a_addr_hold", since_fall_a >= 3, 1);
          hold_pend_a = 0;
        end
      end
      prev_en_a = rd_en_a[0];
      if (start_a) begin
        exp_a       = 0;
        words_a     = 0;
        last_rise_a = -1;
        prev_en_a   = 0;
        hold_pend_a = 0;
      end
    end
  end

  // ---------------- monitor B ----------------
  int             exp_b = 0, words_b = 0;
  logic [AWB-1:0] last_out_b = '0;
  logic [NB-1:0]  seen_b = '0;

  always @(negedge clk) begin
    if (rst_n_b) begin
      if (!start_b && if_b.out_valid && if_b.out_ready) begin
        chk("b_addr", if_b.out_addr, exp_b);
        chk("b_data", if_b.out_data, mem_b[exp_b % (NB*CELLS)]);
        chk("b_last", if_b.out_last, exp_b == NB*CELLS-1);
        last_out_b = if_b.out_addr;
        exp_b++;
        words_b++;
      end
      if (rd_en_b != '0) begin
        chk("b_onehot", rd_en_b, NB'(1) << chip_b);
        seen_b = seen_b | rd_en_b;
      end
      if (start_b) begin
        exp_b   = 0;
        words_b = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic run_a();
    int t;
    bit bad;
    rst_n_a = 0; start_a = 0; if_a.out_ready = 0;
    repeat (3) tick();
    chk("a_rst_ready", ready_a, 1);
    chk("a_rst_rden", rd_en_a, 0);
    chk("a_rst_valid", if_a.out_valid, 0);
    chk("a_rst_last", if_a.out_last, 0);
    chk("a_rst_data", if_a.out_data, 0);
    chk("a_rst_oaddr", if_a.out_addr, 0);
    chk("a_rst_addr", {chip_a, row_a, col_a}, 0);
    rst_n_a = 1;
    repeat (2) tick();

    // full scan, consumer always ready
    per_chk_a = 1; if_a.out_ready = 1;
    start_a = 1; tick(); start_a = 0;
    chk("a_start_ready", ready_a, 0);
    chk("a_start_rden", rd_en_a, 0);
    tick();
    chk("a_rden_rise", rd_en_a, 1);
    t = 0;
    while (!(if_a.out_valid && if_a.out_last) && t < 40000) begin tick(); t++; end
    chk("a_last_timeout", t < 40000, 1);
    chk("a_last_addr", if_a.out_addr, 12'hFFF);
    tick();
    chk("a_ready_at_hs", ready_a, 0);
    tick();
    chk("a_ready_end", ready_a, 1);
    chk("a_words", words_a, NA*CELLS);
    per_chk_a = 0;

    // backpressure at cell 0x041
    start_a = 1; tick(); start_a = 0;
    t = 0;
    while (!(if_a.out_valid && if_a.out_addr == 'h41) && t < 2000) begin tick(); t++; end
    chk("a_bp_timeout", t < 2000, 1);
    if_a.out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("a_bp_valid", if_a.out_valid, 1);
      chk("a_bp_oaddr", if_a.out_addr, 'h41);
      chk("a_bp_data", if_a.out_data, mem_a['h41]);
      chk("a_bp_rden", rd_en_a, 0);
    end
    if_a.out_ready = 1;
    t = 0;
    while (!rd_en_a[0] && t < 50) begin tick(); t++; end
    chk("a_bp_resume", {chip_a, row_a, col_a}, 'h42);

    // random consumer until 0x123 is offered, then restart over it
    t = 0;
    while (!(if_a.out_valid && if_a.out_addr == 'h123) && t < 20000) begin
      if_a.out_ready = ($urandom_range(0, 3) != 0);
      tick(); t++;
    end
    chk("a_123_timeout", t < 20000, 1);
    start_a = 1; tick(); start_a = 0;
    chk("a_rs_valid", if_a.out_valid, 0);
    chk("a_rs_ready", ready_a, 0);
    chk("a_rs_addr", {chip_a, row_a, col_a}, 0);
    t = 0;
    while (!if_a.out_valid && t < 50) begin tick(); t++; end
    chk("a_rs_first", if_a.out_addr, 0);
    repeat (60) begin
      if_a.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // asynchronous reset between edges
    @(posedge clk); #3;
    rst_n_a = 0;
    #1;
    chk("a_arst_ready", ready_a, 1);
    chk("a_arst_rden", rd_en_a, 0);
    chk("a_arst_valid", if_a.out_valid, 0);
    @(posedge clk); #2;
    rst_n_a = 1;
    if_a.out_ready = 1;
    bad = 0;
    repeat (20) begin
      tick();
      if (!ready_a || rd_en_a != 0 || if_a.out_valid) bad = 1;
    end
    chk("a_idle_after_rst", bad, 0);
    start_a = 1; tick(); start_a = 0;
    t = 0;
    while (!if_a.out_valid && t < 50) begin tick(); t++; end
    chk("a_post_rst_first", if_a.out_addr, 0);
    repeat (30) tick();
  endtask

  task automatic run_b();
    int t;
    rst_n_b = 0; start_b = 0; if_b.out_ready = 1;
    repeat (2) tick();
    rst_n_b = 1;
    tick();
    start_b = 1; tick(); start_b = 0;
    t = 0;
    while (!(if_b.out_valid && if_b.out_last) && t < 60000) begin tick(); t++; end
    chk("b_last_timeout", t < 60000, 1);
    tick();
    tick();
    chk("b_ready_end", ready_b, 1);
    chk("b_words", words_b, NB*CELLS);
    chk("b_last_oaddr", last_out_b, 'h2FFF);
    chk("b_chips_seen", seen_b, 3'b111);
  endtask

  initial begin
    foreach (mem_a[i]) mem_a[i] = DW'($urandom);
    foreach (mem_b[i]) mem_b[i] = DW'($urandom);
    fork
      run_a();
      run_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/readback.md
# readback

Read-back sequencer for the COBI weight array: walks every (chip, row, col) cell of one chip chain and pulses a one-hot read enable per cell. After a fixed settle time it samples the chip's read data and streams each word out on a valid/ready interface tagged with its address. It is the reverse-direction companion of the programming sequencer and shares the same address bus layout. Host logic uses it to verify programmed weights.

## Interface
- `NUM_CHIPS_PER_CHAIN`, default 1: chips on the chain; must be ≥1.
- `DATA_WIDTH`, default 4: width of one cell's read data.
- `SETTLE_CLOCKS`, default 4: cycles `rd_en` is high before sampling; must be ≥1.
- `CHIP_ADDR_WIDTH` (localparam): max(clog2(NUM_CHIPS_PER_CHAIN), 1).
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse that begins a full scan.
- `ready`  out  1  high when idle.
- `row_addr`  out  6  cell row, equal to addr[11:6].
- `col_addr`  out  6  cell column, equal to addr[5:0].
- `chip_in_chain_addr`  out  CHIP_ADDR_WIDTH  binary chip index, equal to addr[12+:CHIP_ADDR_WIDTH].
- `rd_en`  out  NUM_CHIPS_PER_CHAIN  one-hot read enable, equal to rd_gate << chip_in_chain_addr.
- `rd_data`  in  DATA_WIDTH  chip read data; valid after settle.
- `out_valid`  out  1  sampled word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_WIDTH  sampled word.
- `out_addr`  out  12+CHIP_ADDR_WIDTH  {chip, row, col} of `out_data`.
- `out_last`  out  1  qualifies the final word of the scan.

## Operation
- Reset values:
  - `ready` = 1.
  - `addr`, `rd_gate`, `out_valid`, `out_last` = 0.
  - `out_data`, `out_addr` = 0.
  - state = S_IDLE.
- States: S_IDLE, S_RD_EN, S_OUT, S_INC.
- Start handling:
  - `start` has priority in every state, including mid-scan.
  - On `start`: `ready`←0, `addr`←0, `cnt`←0, `rd_gate`←0, `out_valid`←0, state←S_RD_EN.
  - Any pending output word is dropped.
- S_RD_EN:
  - `rd_gate`←1 and `cnt` increments.
  - When `cnt`==SETTLE_CLOCKS:
    - `out_data`←`rd_data`, `out_addr`←`addr`, `out_valid`←1.
    - `out_last`←(addr is the last cell).
    - `rd_gate`←0, state←S_OUT.
- S_OUT: hold all outputs. When `out_valid` && `out_ready`: `out_valid`←0, `out_last`←0, state←S_INC.
- S_INC:
  - `addr`←`addr`+1.
  - If the old `addr[11:0]`==12'hFFF and chip==NUM_CHIPS_PER_CHAIN−1: `ready`←1, state←S_IDLE.
  - Otherwise: `cnt`←0, state←S_RD_EN.
- Backpressure: the scan stalls indefinitely in S_OUT. Address and `rd_en` stay stable (`rd_en`=0) during the stall.
- Address change is safe: `addr` only changes in S_INC, at least 2 cycles after `rd_en` falls.
- Row/col wrap: 12'hFFF→0 carries into the chip index.
- Total words per scan: 4096·NUM_CHIPS_PER_CHAIN.

## Timing
- Start: `start` sampled at edge 0 → `ready`=0 after edge 0 → `rd_en` high after edge 1.
- `rd_en` stays high for exactly SETTLE_CLOCKS cycles. `rd_data` is sampled at the edge that drops `rd_en`.
- `out_valid` rises in the same cycle `rd_en` falls.
- Per-word period with `out_ready` held high: SETTLE_CLOCKS+3 cycles (S_RD_EN SETTLE+1, S_OUT 1, S_INC 1).
- End of scan: `ready` rises one cycle after the final handshake.
- `out_valid` never drops without a handshake, except on `start` or reset.

## Structure
- Shared package/include holds:
  - MAX2 macro and CHIP_ADDR_WIDTH derivation;
  - address field offsets (col 0, row 6, chip 12);
  - common sequencer state encodings.
- One natural sub-module, `cobi_chain_addr_counter`:
  - address register, increment, last-cell detect;
  - split-field and one-hot outputs.
  - The programming sequencer should reuse it.
- The output register (data/addr/valid/last) stays inline.

## Test plan
- N=1, SETTLE=4, `out_ready`=1, `rd_data`=col[3:0]:
  - 4096 words, `out_data`==`out_addr[3:0]`;
  - period 7 cycles;
  - `out_last` only on addr 0xFFF;
  - `ready` rises 1 cycle later.
- `rd_en` pulse check: width exactly 4 cycles per cell. `row_addr`/`col_addr` constant during each pulse and ≥2 cycles around it.
- Backpressure: hold `out_ready`=0 for 10 cycles at addr 0x041:
  - `out_valid`, `out_data`, `out_addr`=0x041 stable;
  - no new `rd_en`;
  - resumes at 0x042.
- N=3: chip index steps 0→1→2 at the 0xFFF wraps. `rd_en` = 3'b001, 3'b010, 3'b100. 12288 words, last `out_addr`=0x2FFF.
- `start` at addr 0x123 with `out_valid`=1: `out_valid`→0 next cycle, scan restarts at addr 0, no word 0x123 emitted.
- Assert `rst_n`=0 mid-scan, asynchronously between edges: `ready`=1, `rd_en`=0, `out_valid`=0 immediately; the block stays idle until `start`.
